// File: rtl/vga_win_arb_pkg.sv
// Shared constants, window configuration record and helpers for the VGA window arbiter.
package vga_win_arb_pkg;

  localparam logic [2:0] FLD_X0   = 3'd0;
  localparam logic [2:0] FLD_Y0   = 3'd1;
  localparam logic [2:0] FLD_X1   = 3'd2;
  localparam logic [2:0] FLD_Y1   = 3'd3;
  localparam logic [2:0] FLD_CTRL = 3'd4;

  localparam logic [5:0] ADDR_BG     = 6'h20;
  localparam logic [5:0] ADDR_COMMIT = 6'h21;
  localparam logic [5:0] ADDR_BORDER = 6'h22;

  localparam logic [9:0] BLANK_XY = 10'h3FF;

  // Registered pixel-source selection, decoded by the output mux one cycle later
  localparam logic [1:0] SEL_BLANK  = 2'd0;
  localparam logic [1:0] SEL_BG     = 2'd1;
  localparam logic [1:0] SEL_SRC    = 2'd2;
  localparam logic [1:0] SEL_BORDER = 2'd3;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] x1;
    logic [9:0] y1;
    logic       en;
  } win_cfg_t;

  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_win_arb_if.sv
// Configuration write port of the VGA window arbiter: valid/ready with address and data.
interface vga_win_arb_if;

  logic        cfg_valid;
  logic        cfg_ready;
  logic [5:0]  cfg_addr;
  logic [15:0] cfg_wdata;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_wdata,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_wdata,
    output cfg_ready
  );

endinterface

// File: rtl/vga_win_arb_cmp.sv
// Per-source window comparator: inclusive rectangle hit test plus edge detect.
module vga_win_cmp
  import vga_win_arb_pkg::*;
(
  input  win_cfg_t   cfg,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       hit,
  output logic       on_edge
);

  // x0 > x1 or y0 > y1 can never satisfy both bounds, so such a window stays empty
  assign hit = cfg.en && in_range(pix_x, cfg.x0, cfg.x1) && in_range(pix_y, cfg.y0, cfg.y1);

  assign on_edge = (pix_x == cfg.x0) || (pix_x == cfg.x1) ||
                   (pix_y == cfg.y0) || (pix_y == cfg.y1);

endmodule

// File: rtl/vga_win_arb.sv
// Per-pixel window arbiter with shadow/active window sets committed at frame end.
// Optional border colouring of window edges is enabled by defining VGA_WIN_ARB_BORDER_EN.
module vga_win_arb
  import vga_win_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int H_VALID = 640,
  parameter int V_VALID = 480,
  parameter int DW      = 16
) (
  input  logic                  vga_clk,
  input  logic                  sys_rst,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic [NUM_SRC*DW-1:0] src_data,
  output logic [DW-1:0]         pix_data,
  output logic [NUM_SRC-1:0]    win_hit,
  output logic                  frame_commit,
  vga_win_arb_if.slave          cfg
);

  logic               wr_s;
  logic               commit_s;
  logic               frame_end_r;
  logic               commit_pend_r;
  win_cfg_t           shd_r [NUM_SRC];
  win_cfg_t           act_r [NUM_SRC];
  logic [DW-1:0]      bg_shd_r;
  logic [DW-1:0]      bg_act_r;
  logic [DW-1:0]      border_act_s;
  logic [NUM_SRC-1:0] hit_s;
  logic [NUM_SRC-1:0] edge_s;
  logic [NUM_SRC-1:0] win_oh_s;
  logic               any_hit_s;
  logic               win_edge_s;
  logic               blank_s;
  logic [1:0]         mode_s;
  logic [1:0]         mode_r;
  logic [NUM_SRC-1:0] win_hit_r;
  logic [DW-1:0]      src_pick_s;

  // While a commit is pending the port stalls, so a commit never coincides with a write
  assign cfg.cfg_ready = !commit_pend_r;
  assign wr_s          = cfg.cfg_valid && !commit_pend_r;
  assign commit_s      = frame_end_r && commit_pend_r;
  assign frame_commit  = commit_s;
  assign win_hit       = win_hit_r;

  // Frame-end flag: last active pixel of the frame seen on the previous cycle
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_end_r <= 1'b0;
    end else begin
      frame_end_r <= (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
    end
  end

  // Commit request latch; only a flag set before the frame-end cycle is honoured
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      commit_pend_r <= 1'b0;
    end else if (commit_s) begin
      commit_pend_r <= 1'b0;
    end else if (wr_s && (cfg.cfg_addr == ADDR_COMMIT)) begin
      commit_pend_r <= 1'b1;
    end
  end

  // Shadow window writes; sources beyond NUM_SRC decode to nothing
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        shd_r[s] <= '0;
      end
    end else if (wr_s && !cfg.cfg_addr[5]) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (int'(cfg.cfg_addr[4:3]) == s) begin
          case (cfg.cfg_addr[2:0])
            FLD_X0:   shd_r[s].x0 <= cfg.cfg_wdata[9:0];
            FLD_Y0:   shd_r[s].y0 <= cfg.cfg_wdata[9:0];
            FLD_X1:   shd_r[s].x1 <= cfg.cfg_wdata[9:0];
            FLD_Y1:   shd_r[s].y1 <= cfg.cfg_wdata[9:0];
            FLD_CTRL: shd_r[s].en <= cfg.cfg_wdata[0];
            default:  ;
          endcase
        end
      end
    end
  end

  // Shadow background colour write
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bg_shd_r <= '0;
    end else if (wr_s && (cfg.cfg_addr == ADDR_BG)) begin
      bg_shd_r <= cfg.cfg_wdata[DW-1:0];
    end
  end

  // Shadow-to-active copy, only on the frame-end commit so the picture never tears
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        act_r[s] <= '0;
      end
      bg_act_r <= '0;
    end else if (commit_s) begin
      act_r    <= shd_r;
      bg_act_r <= bg_shd_r;
    end
  end

`ifdef VGA_WIN_ARB_BORDER_EN
  localparam logic BORDER_EN = 1'b1;

  logic [DW-1:0] border_shd_r;
  logic [DW-1:0] border_act_r;

  // Border colour shadow write and frame-end commit
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      border_shd_r <= '0;
      border_act_r <= '0;
    end else begin
      if (wr_s && (cfg.cfg_addr == ADDR_BORDER)) begin
        border_shd_r <= cfg.cfg_wdata[DW-1:0];
      end
      if (commit_s) begin
        border_act_r <= border_shd_r;
      end
    end
  end

  assign border_act_s = border_act_r;
`else
  localparam logic BORDER_EN = 1'b0;

  assign border_act_s = '0;
`endif

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cmp
    vga_win_cmp u_cmp (
      .cfg     (act_r[g]),
      .pix_x   (pix_x),
      .pix_y   (pix_y),
      .hit     (hit_s[g]),
      .on_edge (edge_s[g])
    );
  end

  assign blank_s = (pix_x == BLANK_XY) || (pix_y == BLANK_XY);

  // Fixed-priority encode: the lowest-index hitting window wins
  always_comb begin
    win_oh_s  = '0;
    any_hit_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      win_oh_s[i] = hit_s[i] && !any_hit_s;
      any_hit_s   = any_hit_s || hit_s[i];
    end
    win_edge_s = |(win_oh_s & edge_s);
  end

  // Selection for the next cycle; blanking overrides any window that reaches 0x3FF
  always_comb begin
    mode_s = SEL_BLANK;
    if (blank_s) begin
      mode_s = SEL_BLANK;
    end else if (!any_hit_s) begin
      mode_s = SEL_BG;
    end else if (BORDER_EN && win_edge_s) begin
      mode_s = SEL_BORDER;
    end else begin
      mode_s = SEL_SRC;
    end
  end

  // Selection register: gives the single cycle of pix_x/pix_y to pix_data latency
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_r    <= SEL_BLANK;
      win_hit_r <= '0;
    end else begin
      mode_r    <= mode_s;
      win_hit_r <= blank_s ? '0 : win_oh_s;
    end
  end

  // Output mux; sources register their pixels one cycle late, matching the selection
  always_comb begin
    src_pick_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_pick_s = src_pick_s | (src_data[i*DW +: DW] & {DW{win_hit_r[i]}});
    end
    case (mode_r)
      SEL_BG:     pix_data = bg_act_r;
      SEL_SRC:    pix_data = src_pick_s;
      SEL_BORDER: pix_data = border_act_s;
      default:    pix_data = '0;
    endcase
  end

endmodule

// File: tb/tb_vga_win_arb.sv
// Directed self-checking bench for vga_win_arb; expectations follow the build's VGA_WIN_ARB_BORDER_EN.
module tb_vga_win_arb;
  import vga_win_arb_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int DW      = 16;

  localparam logic [15:0] C_SRC0   = 16'hA000;
  localparam logic [15:0] C_SRC1   = 16'hB111;
  localparam logic [15:0] C_BG     = 16'h001F;
  localparam logic [15:0] C_BORDER = 16'hF800;
`ifdef VGA_WIN_ARB_BORDER_EN
  localparam logic [15:0] E_EDGE0_PRE = 16'h0000;
  localparam logic [15:0] E_EDGE0     = C_BORDER;
  localparam logic [15:0] E_EDGE1     = C_BORDER;
`else
  localparam logic [15:0] E_EDGE0_PRE = C_SRC0;
  localparam logic [15:0] E_EDGE0     = C_SRC0;
  localparam logic [15:0] E_EDGE1     = C_SRC1;
`endif

  logic                  vga_clk;
  logic                  sys_rst;
  logic [9:0]            pix_x;
  logic [9:0]            pix_y;
  logic [NUM_SRC*DW-1:0] src_data;
  logic [DW-1:0]         pix_data;
  logic [NUM_SRC-1:0]    win_hit;
  logic                  frame_commit;
  logic                  fc;
  logic                  rdy;
  int                    total;
  int                    bad;

  vga_win_arb_if cfg_if ();

  vga_win_arb #(
    .NUM_SRC (NUM_SRC),
    .H_VALID (640),
    .V_VALID (480),
    .DW      (DW)
  ) dut (
    .vga_clk      (vga_clk),
    .sys_rst      (sys_rst),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .src_data     (src_data),
    .pix_data     (pix_data),
    .win_hit      (win_hit),
    .frame_commit (frame_commit),
    .cfg          (cfg_if)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic show(input logic [9:0] x, input logic [9:0] y);
    pix_x = x;
    pix_y = y;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [15:0] d);
    int n;
    n = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = a;
    cfg_if.cfg_wdata = d;
    while ((cfg_if.cfg_ready !== 1'b1) && (n < 50)) begin
      @(posedge vga_clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $error("FAIL cfg_timeout observed=ready_low expected=ready_high addr=%0h", a);
    end else begin
      @(posedge vga_clk);
      #1;
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic set_win(input logic [1:0] s, input logic [9:0] x0, input logic [9:0] y0,
                         input logic [9:0] x1, input logic [9:0] y1);
    cfg_write({1'b0, s, FLD_X0}, {6'd0, x0});
    cfg_write({1'b0, s, FLD_Y0}, {6'd0, y0});
    cfg_write({1'b0, s, FLD_X1}, {6'd0, x1});
    cfg_write({1'b0, s, FLD_Y1}, {6'd0, y1});
    cfg_write({1'b0, s, FLD_CTRL}, 16'h0001);
  endtask

  task automatic end_frame(output logic fc_o, output logic rdy_o);
    show(10'd639, 10'd479);
    fc_o  = frame_commit;
    rdy_o = cfg_if.cfg_ready;
    show(BLANK_XY, BLANK_XY);
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    sys_rst          = 1'b1;
    pix_x            = BLANK_XY;
    pix_y            = BLANK_XY;
    src_data         = {16'hD333, 16'hC222, C_SRC1, C_SRC0};
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_addr  = 6'h00;
    cfg_if.cfg_wdata = 16'h0000;
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_pix", pix_data, 16'h0000);
    chk("rst_hit", win_hit, 4'b0000);
    chk("rst_fc", frame_commit, 1'b0);
    chk("rst_ready", cfg_if.cfg_ready, 1'b1);
    sys_rst = 1'b0;

    show(10'd10, 10'd10);
    chk("noc_active_pix", pix_data, 16'h0000);
    chk("noc_active_hit", win_hit, 4'b0000);
    show(BLANK_XY, 10'd10);
    chk("noc_blank_pix", pix_data, 16'h0000);

    // src0 window and background, then commit
    set_win(2'd0, 10'd100, 10'd50, 10'd199, 10'd149);
    cfg_write(ADDR_BG, C_BG);
    show(10'd150, 10'd60);
    chk("shadow_only_pix", pix_data, 16'h0000);
    chk("shadow_only_hit", win_hit, 4'b0000);
    show(BLANK_XY, BLANK_XY);
    cfg_write(ADDR_COMMIT, 16'h0000);
    chk("pend_ready", cfg_if.cfg_ready, 1'b0);
    show(10'd150, 10'd60);
    chk("pend_fc", frame_commit, 1'b0);
    chk("pend_pix", pix_data, 16'h0000);
    end_frame(fc, rdy);
    chk("c1_fc", fc, 1'b1);
    chk("c1_ready_at_fe", rdy, 1'b0);
    chk("c1_ready_after", cfg_if.cfg_ready, 1'b1);
    chk("c1_fc_once", frame_commit, 1'b0);
    show(10'd100, 10'd50);
    chk("c1_corner_pix", pix_data, E_EDGE0_PRE);
    chk("c1_corner_hit", win_hit, 4'b0001);
    show(10'd150, 10'd60);
    chk("c1_inner_pix", pix_data, C_SRC0);
    show(10'd200, 10'd50);
    chk("c1_right_pix", pix_data, C_BG);
    chk("c1_right_hit", win_hit, 4'b0000);
    show(10'd99, 10'd50);
    chk("c1_left_pix", pix_data, C_BG);
    show(10'd150, 10'd150);
    chk("c1_below_pix", pix_data, C_BG);
    show(BLANK_XY, 10'd60);
    chk("c1_blank_pix", pix_data, 16'h0000);
    chk("c1_blank_hit", win_hit, 4'b0000);

    // overlapping src1 window
    show(BLANK_XY, BLANK_XY);
    set_win(2'd1, 10'd150, 10'd100, 10'd299, 10'd199);
    cfg_write(ADDR_COMMIT, 16'h0000);
    end_frame(fc, rdy);
    chk("c2_fc", fc, 1'b1);
    show(10'd160, 10'd110);
    chk("ovl_pix", pix_data, C_SRC0);
    chk("ovl_hit", win_hit, 4'b0001);
    show(10'd250, 10'd160);
    chk("src1_pix", pix_data, C_SRC1);
    chk("src1_hit", win_hit, 4'b0010);

    // shadow x1 change held back for three frames
    show(BLANK_XY, BLANK_XY);
    cfg_write({1'b0, 2'd0, FLD_X1}, 16'd300);
    for (int f = 0; f < 3; f++) begin
      end_frame(fc, rdy);
      chk("hold_fc", fc, 1'b0);
      show(10'd250, 10'd60);
      chk("hold_pix", pix_data, C_BG);
      show(BLANK_XY, BLANK_XY);
    end
    cfg_write(ADDR_COMMIT, 16'h0000);
    show(10'd250, 10'd60);
    chk("pre_commit_pix", pix_data, C_BG);
    end_frame(fc, rdy);
    chk("c3_fc", fc, 1'b1);
    show(10'd250, 10'd60);
    chk("post_commit_pix", pix_data, C_SRC0);
    chk("post_commit_hit", win_hit, 4'b0001);

    // empty window x0 > x1, plus border colour
    show(BLANK_XY, BLANK_XY);
    set_win(2'd2, 10'd300, 10'd0, 10'd299, 10'd479);
    cfg_write(ADDR_BORDER, C_BORDER);
    cfg_write(ADDR_COMMIT, 16'h0000);
    end_frame(fc, rdy);
    chk("c4_fc", fc, 1'b1);
    show(10'd300, 10'd300);
    chk("empty_pix_a", pix_data, C_BG);
    chk("empty_hit_a", win_hit, 4'b0000);
    show(10'd299, 10'd300);
    chk("empty_pix_b", pix_data, C_BG);
    show(10'd100, 10'd50);
    chk("edge0_pix", pix_data, E_EDGE0);
    chk("edge0_hit", win_hit, 4'b0001);
    show(10'd299, 10'd199);
    chk("edge1_pix", pix_data, E_EDGE1);
    chk("edge1_hit", win_hit, 4'b0010);
    show(10'd150, 10'd60);
    chk("inner0_pix", pix_data, C_SRC0);

    // commit written in the frame-end cycle waits a whole frame
    show(10'd639, 10'd479);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = ADDR_COMMIT;
    cfg_if.cfg_wdata = 16'h0000;
    pix_x = 10'd10;
    pix_y = 10'd10;
    @(posedge vga_clk);
    #1;
    cfg_if.cfg_valid = 1'b0;
    chk("late_fc0", frame_commit, 1'b0);
    chk("late_ready0", cfg_if.cfg_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      show(10'd20, 10'd20);
      chk("late_ready_mid", cfg_if.cfg_ready, 1'b0);
      chk("late_fc_mid", frame_commit, 1'b0);
    end
    end_frame(fc, rdy);
    chk("late_fc", fc, 1'b1);
    chk("late_ready_fe", rdy, 1'b0);
    chk("late_ready_after", cfg_if.cfg_ready, 1'b1);

    // reset while a commit is pending
    cfg_write(ADDR_COMMIT, 16'h0000);
    chk("rst2_pend_ready", cfg_if.cfg_ready, 1'b0);
    show(10'd150, 10'd60);
    sys_rst = 1'b1;
    #1;
    chk("rst2_ready", cfg_if.cfg_ready, 1'b1);
    chk("rst2_pix", pix_data, 16'h0000);
    chk("rst2_hit", win_hit, 4'b0000);
    @(posedge vga_clk);
    #1;
    sys_rst = 1'b0;
    end_frame(fc, rdy);
    chk("rst2_fc", fc, 1'b0);
    show(10'd150, 10'd60);
    chk("rst2_win_pix", pix_data, 16'h0000);
    chk("rst2_win_hit", win_hit, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
